// File: rtl/trace_stream_tx_if.sv
// Trace output link between trace_stream_tx (master) and its sink (slave).
//
// Handshake: a word transfers on a rising edge where tx_valid & tx_ready are
// both 1. Once tx_valid is raised, tx_data and tx_last hold stable until
// that transfer. tx_valid never depends combinationally on tx_ready, and
// the sink may drive tx_ready freely.
interface trace_stream_tx_if;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_last;

  modport master (output tx_data, output tx_valid, output tx_last, input tx_ready);
  modport slave  (input tx_data, input tx_valid, input tx_last, output tx_ready);
endinterface

// File: rtl/trace_stream_tx.sv
// trace_stream_tx: commit-trace transmitter for the MIPS54 multicycle SoC.
// Watches pc/inst. Each pc change becomes a {pc, inst} record in a small
// FIFO, and the records are streamed out as 32-bit words (pc word, then
// inst word with tx_last=1).
// Optional macro TRACE_HDR_EN adds a leading header word per record:
// {8'hC3, seq[7:0], drop_count[15:0]}.
// fsm_state exposes the output FSM state for debug and checkers.
module trace_stream_tx #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter int          CNT_W      = 16
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic [31:0]      pc,
  input  logic [31:0]      inst,
  input  logic             trace_en,
  trace_stream_tx_if.master tx,
  output logic             overflow,
  output logic [CNT_W-1:0] drop_count,
  output logic [1:0]       fsm_state
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND_PC   = 2'd1,
    SEND_INST = 2'd2
`ifdef TRACE_HDR_EN
    , SEND_HDR = 2'd3
`endif
  } state_t;

  logic [31:0] mem_pc   [FIFO_DEPTH];
  logic [31:0] mem_inst [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [31:0] prev_pc;
  logic        empty, full, pc_changed, push, pop;
  logic [31:0] head_pc, head_inst;

  state_t      state;
  logic [31:0] data_q;
  logic        valid_q, last_q;
  logic [31:0] hold_inst;
`ifdef TRACE_HDR_EN
  logic [31:0] hold_pc;
  logic [7:0]  seq;
  logic [7:0]  seq_hdr;
  logic [31:0] hdr_word;
`endif

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign pc_changed = trace_en && (pc != prev_pc);
  assign push       = pc_changed && !full;
  // The transmitter takes a new record when it is free, or when the last
  // word of the current record is leaving on this edge.
  assign pop        = !empty && ((state == IDLE) || ((state == SEND_INST) && tx.tx_ready));
  assign head_pc    = mem_pc[rd_ptr[AW-1:0]];
  assign head_inst  = mem_inst[rd_ptr[AW-1:0]];

`ifdef TRACE_HDR_EN
  // A record starting from SEND_INST follows one completing on the same edge.
  assign seq_hdr  = (state == SEND_INST) ? seq + 8'd1 : seq;
  assign hdr_word = {8'hC3, seq_hdr, 16'(drop_count)};
`endif

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk_in) begin
    if (push) begin
      mem_pc[wr_ptr[AW-1:0]]   <= pc;
      mem_inst[wr_ptr[AW-1:0]] <= inst;
    end
  end

  // Capture side: change detection, push, and drop accounting.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      wr_ptr     <= '0;
      prev_pc    <= RESET_PC;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (trace_en) begin
      prev_pc <= pc;
      if (pc_changed) begin
        if (full) begin
          overflow <= 1'b1;
          if (drop_count != '1) drop_count <= drop_count + 1'b1;
        end else begin
          wr_ptr <= wr_ptr + 1'b1;
        end
      end
    end
  end

  // Output FSM with registered link outputs; pops load the hold registers.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      state     <= IDLE;
      rd_ptr    <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      hold_inst <= '0;
`ifdef TRACE_HDR_EN
      hold_pc   <= '0;
      seq       <= '0;
`endif
    end else begin
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        hold_inst <= head_inst;
`ifdef TRACE_HDR_EN
        hold_pc   <= head_pc;
`endif
      end
      case (state)
        IDLE: begin
          if (!empty) begin
            valid_q <= 1'b1;
            last_q  <= 1'b0;
`ifdef TRACE_HDR_EN
            data_q  <= hdr_word;
            state   <= SEND_HDR;
`else
            data_q  <= head_pc;
            state   <= SEND_PC;
`endif
          end
        end
`ifdef TRACE_HDR_EN
        SEND_HDR: begin
          if (tx.tx_ready) begin
            data_q <= hold_pc;
            last_q <= 1'b0;
            state  <= SEND_PC;
          end
        end
`endif
        SEND_PC: begin
          if (tx.tx_ready) begin
            data_q <= hold_inst;
            last_q <= 1'b1;
            state  <= SEND_INST;
          end
        end
        SEND_INST: begin
          if (tx.tx_ready) begin
`ifdef TRACE_HDR_EN
            seq <= seq + 8'd1;
`endif
            if (!empty) begin
              last_q <= 1'b0;
`ifdef TRACE_HDR_EN
              data_q <= hdr_word;
              state  <= SEND_HDR;
`else
              data_q <= head_pc;
              state  <= SEND_PC;
`endif
            end else begin
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              state   <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign tx.tx_data  = data_q;
  assign tx.tx_valid = valid_q;
  assign tx.tx_last  = last_q;
  assign fsm_state   = state;

endmodule

// File: tb/tb_trace_stream_tx.sv
// Bench for trace_stream_tx: randomized pc/inst/trace_en/tx_ready stimulus
// against a record-level reference model (queue of pending records plus the
// word list of the record currently on the link).
module tb_trace_stream_tx;
  localparam int          DEPTH  = 8;
  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam int          CW     = 16;

  logic          clk_in = 1'b0;
  logic          reset;
  logic [31:0]   pc, inst;
  logic          trace_en;
  logic          overflow;
  logic [CW-1:0] drop_count;
  logic [1:0]    fsm_state;

  trace_stream_tx_if tx_bus ();

  trace_stream_tx #(.FIFO_DEPTH(DEPTH), .RESET_PC(RST_PC), .CNT_W(CW)) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .pc         (pc),
    .inst       (inst),
    .trace_en   (trace_en),
    .tx         (tx_bus),
    .overflow   (overflow),
    .drop_count (drop_count),
    .fsm_state  (fsm_state)
  );

  // ---------------- clock ----------------
  always #5 clk_in = ~clk_in;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;

  logic [63:0] rec_q[$];          // captured records {pc, inst} awaiting transmit
  logic [32:0] exp_q[$];          // {last, word} still to leave for the current record
  logic [31:0] m_prev_pc = RST_PC;
  int          m_drops   = 0;
  bit          m_ovf     = 1'b0;
  int          m_seq     = 0;
  bit          stall_prev = 1'b0;
  logic [31:0] stall_data;
  logic        stall_last;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Compare registered outputs against the model state after the last edge.
  task automatic check_outputs();
    bit mv;
    mv = (exp_q.size() > 0);
    check("tx_valid", {63'd0, tx_bus.tx_valid}, {63'd0, mv});
    if (mv) begin
      check("tx_data", {32'd0, tx_bus.tx_data}, {32'd0, exp_q[0][31:0]});
      check("tx_last", {63'd0, tx_bus.tx_last}, {63'd0, exp_q[0][32]});
    end
    if (stall_prev && tx_bus.tx_valid) begin
      check("stall_data", {32'd0, tx_bus.tx_data}, {32'd0, stall_data});
      check("stall_last", {63'd0, tx_bus.tx_last}, {63'd0, stall_last});
    end
    check("overflow", {63'd0, overflow}, {63'd0, m_ovf});
    check("drop_count", {48'd0, drop_count}, 64'(m_drops));
    stall_prev = tx_bus.tx_valid && !tx_bus.tx_ready;
    stall_data = tx_bus.tx_data;
    stall_last = tx_bus.tx_last;
  endtask

  // Advance the model by one rising edge using the inputs now applied.
  task automatic model_edge();
    bit was_full;
    logic [63:0] rec;
    if (!reset) begin
      rec_q.delete();
      exp_q.delete();
      m_prev_pc  = RST_PC;
      m_drops    = 0;
      m_ovf      = 1'b0;
      m_seq      = 0;
      stall_prev = 1'b0;
      return;
    end
    was_full = (rec_q.size() >= DEPTH);
    if (exp_q.size() > 0 && tx_bus.tx_ready) begin
      if (exp_q[0][32]) m_seq = (m_seq + 1) % 256;
      void'(exp_q.pop_front());
    end
    if (exp_q.size() == 0 && rec_q.size() > 0) begin
      rec = rec_q.pop_front();
`ifdef TRACE_HDR_EN
      exp_q.push_back({1'b0, 8'hC3, 8'(m_seq), 16'(m_drops)});
`endif
      exp_q.push_back({1'b0, rec[63:32]});
      exp_q.push_back({1'b1, rec[31:0]});
    end
    if (trace_en) begin
      if (pc != m_prev_pc) begin
        if (was_full) begin
          m_ovf = 1'b1;
          if (m_drops < (1 << CW) - 1) m_drops++;
        end else begin
          rec_q.push_back({pc, inst});
        end
      end
      m_prev_pc = pc;
    end
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic rst_n, input logic en, input logic [31:0] p,
                       input logic [31:0] i, input logic rdy);
    reset           = rst_n;
    trace_en        = en;
    pc              = p;
    inst            = i;
    tx_bus.tx_ready = rdy;
    @(negedge clk_in);
    check_outputs();
    model_edge();
    @(posedge clk_in);
    #1;
  endtask

  logic [31:0] cur_pc;
  logic        en_r, rdy_r;
  int          rdy_bias;

  initial begin
    reset = 1'b0; trace_en = 1'b0; pc = RST_PC; inst = '0; tx_bus.tx_ready = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    check("rst_tx_data", {32'd0, tx_bus.tx_data}, 64'd0);
    check("rst_tx_valid", {63'd0, tx_bus.tx_valid}, 64'd0);
    check("rst_tx_last", {63'd0, tx_bus.tx_last}, 64'd0);
    check("rst_overflow", {63'd0, overflow}, 64'd0);
    check("rst_drop_count", {48'd0, drop_count}, 64'd0);

    // pc sits at the reset value: nothing may be sent.
    repeat (20) cycle(1'b1, 1'b1, RST_PC, $urandom, 1'($urandom_range(0, 1)));

    // Single record with the sink always ready.
    cur_pc = 32'h0040_0004;
    cycle(1'b1, 1'b1, cur_pc, 32'h3c01_0000, 1'b1);
    repeat (6) cycle(1'b1, 1'b1, cur_pc, $urandom, 1'b1);

    // Stalled sink while pc changes every cycle, then drain.
    for (int k = 0; k < 10; k++) begin
      cur_pc = cur_pc + 32'd4;
      cycle(1'b1, 1'b1, cur_pc, $urandom, 1'b0);
    end
    check("ovf_sticky", {63'd0, overflow}, 64'd1);
    repeat (30) cycle(1'b1, 1'b1, cur_pc, $urandom, 1'b1);

    // Ready toggling during a record.
    cur_pc = cur_pc + 32'd4;
    cycle(1'b1, 1'b1, cur_pc, $urandom, 1'b0);
    for (int k = 0; k < 8; k++) cycle(1'b1, 1'b1, cur_pc, $urandom, 1'(k % 2 == 0));

    // Reset while mid-record with records queued.
    for (int k = 0; k < 3; k++) begin
      cur_pc = cur_pc + 32'd4;
      cycle(1'b1, 1'b1, cur_pc, $urandom, 1'b0);
    end
    cycle(1'b1, 1'b1, cur_pc, $urandom, 1'b0);
    cycle(1'b0, 1'b1, cur_pc, $urandom, 1'b0);
    check("rst_mid_valid", {63'd0, tx_bus.tx_valid}, 64'd0);
    check("rst_mid_drops", {48'd0, drop_count}, 64'd0);
    cur_pc = 32'h0040_0100;
    cycle(1'b1, 1'b1, cur_pc, 32'h2402_0005, 1'b1);
    repeat (6) cycle(1'b1, 1'b1, cur_pc, $urandom, 1'b1);

    // Randomized traffic with varying sink pressure and trace_en gaps.
    for (int blk = 0; blk < 30; blk++) begin
      rdy_bias = $urandom_range(1, 9);
      for (int k = 0; k < 100; k++) begin
        en_r  = ($urandom_range(0, 9) != 0);
        rdy_r = ($urandom_range(0, 9) < rdy_bias);
        if ($urandom_range(0, 1) == 1) begin
          if ($urandom_range(0, 15) == 0) cur_pc = RST_PC;
          else cur_pc = cur_pc + 32'(4 * $urandom_range(1, 4));
        end
        cycle(($urandom_range(0, 499) != 0), en_r, cur_pc, $urandom, rdy_r);
      end
    end

    // Drain.
    repeat (40) cycle(1'b1, 1'b1, cur_pc, $urandom, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
